// File: rtl/glitch_sequencer_pkg.sv
// Shared definitions for the glitch sequencer: state encodings, default
// widths and a small width helper.
//
// State encodings (3-bit): IDLE=0, ARMED=1, DELAY=2, GLITCH=3, COOL=4, DONE=5.
// Default widths: delay/step/end 16, pulse width 8, cooldown 16, attempts 16.
package glitch_sequencer_pkg;

   localparam int DELAY_W_DEF = 16;
   localparam int WIDTH_W_DEF = 8;
   localparam int COOL_W_DEF  = 16;
   localparam int CNT_W_DEF   = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARMED  = 3'd1,
      S_DELAY  = 3'd2,
      S_GLITCH = 3'd3,
      S_COOL   = 3'd4,
      S_DONE   = 3'd5
   } seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/glitch_sequencer_trig_edge_sync.sv
// trig_edge_sync: two-flop synchronizer followed by an edge register and a
// rising-edge detector. Reusable for any asynchronous pin.
//
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset, clears all three flops
//   in   - asynchronous input pin
//   rise - one-cycle pulse on a synchronized 0->1 transition (s2 & ~s3)
module trig_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: schedules fault-injection glitch requests. After arm it
// waits for a trigger rising edge, counts cur_delay cycles, drives glitch_out
// for width cycles, idles for cooldown cycles, then steps cur_delay through a
// start/step/end sweep until the sweep is exhausted.
//
// Optional feature macro: GLITCH_SEQUENCER_ABORT_EN adds the abort port, which
// forces DONE from any busy state (glitch_out drops on the next cycle and the
// aborted glitch is not counted).
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   arm                 - single-cycle start pulse (honoured in IDLE/DONE)
//   trigger             - asynchronous target trigger
//   delay_start/step/end- sweep bounds and increment (latched on arm)
//   width               - glitch pulse width, 0 treated as 1 (latched on arm)
//   cooldown            - idle cycles after each glitch (latched on arm)
//   abort               - only with GLITCH_SEQUENCER_ABORT_EN
//   glitch_out          - registered glitch request
//   busy, done          - status
//   attempts            - glitches issued since arm, saturating
//   cur_delay           - delay of the current or next attempt
//
// state  | meaning
// IDLE   | after reset, waiting for arm
// ARMED  | waiting for a synchronized trigger rising edge
// DELAY  | counting cur_delay cycles
// GLITCH | glitch_out high for width cycles
// COOL   | cooldown before re-arming or finishing
// DONE   | sweep exhausted (or aborted), waiting for arm
module glitch_sequencer
   import glitch_sequencer_pkg::*;
#(
   parameter int DELAY_W = DELAY_W_DEF,
   parameter int WIDTH_W = WIDTH_W_DEF,
   parameter int COOL_W  = COOL_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic               trigger,
   input  logic [DELAY_W-1:0] delay_start,
   input  logic [DELAY_W-1:0] delay_step,
   input  logic [DELAY_W-1:0] delay_end,
   input  logic [WIDTH_W-1:0] width,
   input  logic [COOL_W-1:0]  cooldown,
`ifdef GLITCH_SEQUENCER_ABORT_EN
   input  logic               abort,
`endif
   output logic               glitch_out,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   attempts,
   output logic [DELAY_W-1:0] cur_delay
);

   localparam int CTR_W = max3(DELAY_W, WIDTH_W, COOL_W);

   seq_state_t         state;
   seq_state_t         state_nxt;
   logic [CTR_W-1:0]   cnt;
   logic [CTR_W-1:0]   cnt_nxt;
   logic [DELAY_W-1:0] cur_delay_nxt;
   logic [CNT_W-1:0]   attempts_nxt;
   logic               latch_en;

   logic [DELAY_W-1:0] step_q;
   logic [DELAY_W-1:0] end_q;
   logic [WIDTH_W-1:0] width_q;
   logic [COOL_W-1:0]  cool_q;

   logic               trig_rise;
   logic [DELAY_W:0]   next_sum;
   logic               sweep_over;
   logic [CTR_W-1:0]   width_cnt;
   logic [CTR_W-1:0]   delay_cnt;
   logic [CTR_W-1:0]   cool_cnt;
   logic [CNT_W-1:0]   attempts_inc;

   trig_edge_sync u_trig_sync (
      .clk  (clk),
      .rst  (rst),
      .in   (trigger),
      .rise (trig_rise)
   );

   // The shared counter is loaded with (cycles - 1) and the phase ends on the
   // cycle it reads 0, so each phase lasts exactly the programmed count.
   assign width_cnt = (width_q == '0) ? '0 : CTR_W'(width_q - WIDTH_W'(1));
   assign delay_cnt = CTR_W'(cur_delay - DELAY_W'(1));
   assign cool_cnt  = CTR_W'(cool_q - COOL_W'(1));

   // Extra bit catches wrap-around so an overflowing step ends the sweep.
   assign next_sum   = {1'b0, cur_delay} + {1'b0, step_q};
   assign sweep_over = next_sum[DELAY_W] | (next_sum[DELAY_W-1:0] > end_q);

   assign attempts_inc = (&attempts) ? attempts : attempts + CNT_W'(1);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      cur_delay_nxt = cur_delay;
      attempts_nxt  = attempts;
      latch_en      = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (arm) begin
               latch_en      = 1'b1;
               cur_delay_nxt = delay_start;
               attempts_nxt  = '0;
               state_nxt     = (delay_start > delay_end) ? S_DONE : S_ARMED;
            end
         end
         S_ARMED: begin
            if (trig_rise) begin
               if (cur_delay == '0) begin
                  state_nxt = S_GLITCH;
                  cnt_nxt   = width_cnt;
               end else begin
                  state_nxt = S_DELAY;
                  cnt_nxt   = delay_cnt;
               end
            end
         end
         S_DELAY: begin
            if (cnt == '0) begin
               state_nxt = S_GLITCH;
               cnt_nxt   = width_cnt;
            end else begin
               cnt_nxt = cnt - CTR_W'(1);
            end
         end
         S_GLITCH: begin
            if (cnt == '0) begin
               attempts_nxt = attempts_inc;
               if (cool_q != '0) begin
                  state_nxt = S_COOL;
                  cnt_nxt   = cool_cnt;
               end else if (sweep_over) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt     = S_ARMED;
                  cur_delay_nxt = next_sum[DELAY_W-1:0];
               end
            end else begin
               cnt_nxt = cnt - CTR_W'(1);
            end
         end
         S_COOL: begin
            if (cnt == '0) begin
               if (sweep_over) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt     = S_ARMED;
                  cur_delay_nxt = next_sum[DELAY_W-1:0];
               end
            end else begin
               cnt_nxt = cnt - CTR_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
`ifdef GLITCH_SEQUENCER_ABORT_EN
      // Abort overrides whatever the busy state decided, including the
      // attempt count of a glitch that would have completed this cycle.
      if (abort && busy) begin
         state_nxt     = S_DONE;
         cnt_nxt       = cnt;
         cur_delay_nxt = cur_delay;
         attempts_nxt  = attempts;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         cur_delay  <= '0;
         attempts   <= '0;
         glitch_out <= 1'b0;
         step_q     <= '0;
         end_q      <= '0;
         width_q    <= '0;
         cool_q     <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         cur_delay  <= cur_delay_nxt;
         attempts   <= attempts_nxt;
         // Registered from the next state so it tracks GLITCH exactly.
         glitch_out <= (state_nxt == S_GLITCH);
         if (latch_en) begin
            step_q  <= delay_step;
            end_q   <= delay_end;
            width_q <= width;
            cool_q  <= cooldown;
         end
      end
   end

   assign busy = (state == S_ARMED) || (state == S_DELAY) ||
                 (state == S_GLITCH) || (state == S_COOL);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer. Timing reference: trigger is driven
// high just after an edge; glitch_out is first seen high 3 + cur_delay edges
// later (4 + cur_delay cycles counting the drive cycle).
module tb_glitch_sequencer;

   logic        clk;
   logic        rst;
   logic        arm;
   logic        trigger;
   logic [15:0] delay_start;
   logic [15:0] delay_step;
   logic [15:0] delay_end;
   logic [7:0]  width;
   logic [15:0] cooldown;
   logic        abort;
   logic        glitch_out;
   logic        busy;
   logic        done;
   logic [15:0] attempts;
   logic [15:0] cur_delay;

   logic [3:0]  d4_start;
   logic [3:0]  d4_step;
   logic [3:0]  d4_end;
   logic        glitch4;
   logic        busy4;
   logic        done4;
   logic [15:0] attempts4;
   logic [3:0]  cur_delay4;

   int n_tests = 0;
   int n_fail  = 0;

   glitch_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .arm         (arm),
      .trigger     (trigger),
      .delay_start (delay_start),
      .delay_step  (delay_step),
      .delay_end   (delay_end),
      .width       (width),
      .cooldown    (cooldown),
`ifdef GLITCH_SEQUENCER_ABORT_EN
      .abort       (abort),
`endif
      .glitch_out  (glitch_out),
      .busy        (busy),
      .done        (done),
      .attempts    (attempts),
      .cur_delay   (cur_delay)
   );

   glitch_sequencer #(.DELAY_W(4)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .arm         (arm),
      .trigger     (trigger),
      .delay_start (d4_start),
      .delay_step  (d4_step),
      .delay_end   (d4_end),
      .width       (width),
      .cooldown    (cooldown),
`ifdef GLITCH_SEQUENCER_ABORT_EN
      .abort       (abort),
`endif
      .glitch_out  (glitch4),
      .busy        (busy4),
      .done        (done4),
      .attempts    (attempts4),
      .cur_delay   (cur_delay4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_arm(input logic [15:0] s, input logic [15:0] st,
                            input logic [15:0] e, input logic [7:0] w,
                            input logic [15:0] c);
      delay_start = s;
      delay_step  = st;
      delay_end   = e;
      width       = w;
      cooldown    = c;
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   // Pulse trigger for two cycles, then watch nsteps edges in total.
   task automatic run_trig(input int nsteps, output int first, output int nhigh,
                           output int done_at);
      first = -1;
      nhigh = 0;
      done_at = -1;
      trigger = 1'b1;
      for (int k = 1; k <= nsteps; k++) begin
         step();
         if (k == 2) trigger = 1'b0;
         if (glitch_out) begin
            if (first < 0) first = k;
            nhigh++;
         end
         if (done && done_at < 0) done_at = k;
      end
   endtask

   // Trigger and stop on the first glitch_out cycle (bounded).
   task automatic trig_to_glitch(output int n);
      n = 0;
      trigger = 1'b1;
      while (!glitch_out && n < 40) begin
         step();
         n++;
         if (n == 2) trigger = 1'b0;
      end
      trigger = 1'b0;
   endtask

   initial begin
      int first, nhigh, done_at, n;
      rst = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
      delay_start = '0; delay_step = '0; delay_end = '0; width = '0; cooldown = '0;
      d4_start = 4'd1; d4_step = 4'd0; d4_end = 4'd0;
      repeat (3) step();
      rst = 1'b0;

      check("rst_glitch", glitch_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_attempts", attempts, 0);
      check("rst_cur_delay", cur_delay, 0);

      // Single attempt: start=end=5, width 3, cooldown 2.
      pulse_arm(16'd5, 16'd1, 16'd5, 8'd3, 16'd2);
      check("single_busy", busy, 1);
      check("single_cur_delay", cur_delay, 5);
      run_trig(20, first, nhigh, done_at);
      check("single_first", first, 8);
      check("single_width", nhigh, 3);
      check("single_done_at", done_at, 13);
      check("single_attempts", attempts, 1);
      check("single_busy_end", busy, 0);

      // Sweep 0,2,4,6 with width 1, cooldown 3.
      pulse_arm(16'd0, 16'd2, 16'd6, 8'd1, 16'd3);
      for (int i = 0; i < 4; i++) begin
         run_trig(16, first, nhigh, done_at);
         check("sweep_first", first, 3 + 2 * i);
         check("sweep_width", nhigh, 1);
         check("sweep_attempts", attempts, i + 1);
         check("sweep_done_at", done_at, (i == 3) ? 13 : -1);
         check("sweep_cur_delay", cur_delay, (i == 3) ? 6 : 2 * (i + 1));
      end
      check("sweep_done", done, 1);

      // Dropped triggers: extra edges land in DELAY and in COOL.
      pulse_arm(16'd4, 16'd1, 16'd5, 8'd2, 16'd4);
      first = -1;
      nhigh = 0;
      for (int k = 0; k < 25; k++) begin
         trigger = (k < 2) || (k >= 4 && k < 6) || (k >= 9 && k < 11);
         step();
         if (glitch_out) begin
            if (first < 0) first = k + 1;
            nhigh++;
         end
      end
      trigger = 1'b0;
      check("drop_first", first, 7);
      check("drop_glitch_cycles", nhigh, 2);
      check("drop_attempts", attempts, 1);
      check("drop_busy", busy, 1);
      check("drop_cur_delay", cur_delay, 5);
      run_trig(20, first, nhigh, done_at);
      check("drop2_first", first, 8);
      check("drop2_attempts", attempts, 2);
      check("drop2_done_at", done_at, 14);

      // Reset during the second GLITCH cycle.
      pulse_arm(16'd3, 16'd1, 16'd10, 8'd4, 16'd1);
      trig_to_glitch(n);
      check("rstg_reached", glitch_out, 1);
      check("rstg_latency", n, 6);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstg_glitch", glitch_out, 0);
      check("rstg_busy", busy, 0);
      check("rstg_attempts", attempts, 0);
      check("rstg_cur_delay", cur_delay, 0);
      arm = 1'b1;
      rst = 1'b1;
      step();
      arm = 1'b0;
      rst = 1'b0;
      check("arm_vs_rst_busy", busy, 0);
      pulse_arm(16'd3, 16'd1, 16'd10, 8'd4, 16'd1);
      check("rearm_cur_delay", cur_delay, 3);
      run_trig(20, first, nhigh, done_at);
      check("rearm_first", first, 6);
      check("rearm_width", nhigh, 4);
      check("rearm_attempts", attempts, 1);
      check("rearm_cur_delay_next", cur_delay, 4);

      // arm while ARMED is ignored.
      pulse_arm(16'd7, 16'd1, 16'd3, 8'd1, 16'd0);
      check("arm_ignored_cur_delay", cur_delay, 4);
      check("arm_ignored_busy", busy, 1);

      // start > end goes straight to DONE.
      rst = 1'b1;
      step();
      rst = 1'b0;
      pulse_arm(16'd7, 16'd1, 16'd3, 8'd1, 16'd0);
      check("empty_done", done, 1);
      check("empty_busy", busy, 0);
      check("empty_attempts", attempts, 0);
      check("empty_cur_delay", cur_delay, 7);

`ifdef GLITCH_SEQUENCER_ABORT_EN
      pulse_arm(16'd2, 16'd1, 16'd9, 8'd5, 16'd1);
      trig_to_glitch(n);
      check("abort_reached", glitch_out, 1);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_glitch", glitch_out, 0);
      check("abort_done", done, 1);
      check("abort_attempts", attempts, 0);
`endif

      // Overflow in a 4-bit delay: 14 + 3 wraps, sweep must end after one.
      d4_start = 4'd14;
      d4_step  = 4'd3;
      d4_end   = 4'd15;
      pulse_arm(16'd7, 16'd1, 16'd3, 8'd1, 16'd0);
      check("ovf_busy", busy4, 1);
      check("ovf_cur_delay_start", cur_delay4, 14);
      first = -1;
      nhigh = 0;
      done_at = -1;
      for (int k = 0; k < 25; k++) begin
         trigger = (k < 2);
         step();
         if (glitch4) begin
            if (first < 0) first = k + 1;
            nhigh++;
         end
         if (done4 && done_at < 0) done_at = k + 1;
      end
      trigger = 1'b0;
      check("ovf_first", first, 17);
      check("ovf_width", nhigh, 1);
      check("ovf_done_at", done_at, 18);
      check("ovf_attempts", attempts4, 1);
      check("ovf_cur_delay", cur_delay4, 14);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
